// File: rtl/fifo_rd_stream_adapter.sv
// Async FIFO read-side adapter: pops FIFO words into a 2-entry valid/ready buffer.
// Optional xfer_cnt output and counter when FIFO_RD_STREAM_XFER_CNT_EN is defined.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_STREAM_XFER_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_level
`ifdef FIFO_RD_STREAM_XFER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  state;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  pop;
  logic [1:0]            pending;

  assign pop       = m_valid & m_ready;
  assign m_data    = entry0;
  assign buf_level = state;

  // Words that will be held after this edge without a new issue
  always_comb begin
    pending = 2'(state) + 2'(inflight) - 2'(pop);
  end

  // Issue only when a worst-case arrival still fits the buffer
  assign fifo_rd_en = !rst && !fifo_empty && (pending < 2'd2);

  // Occupancy FSM: buffer writes, shifts and registered m_valid
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      entry0   <= '0;
      entry1   <= '0;
      m_valid  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      unique case (state)
        EMPTY: begin
          if (inflight) begin
            entry0  <= fifo_rd_data;
            state   <= ONE;
            m_valid <= 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            (pop && inflight): begin
              entry0 <= fifo_rd_data;
            end
            (pop && !inflight): begin
              state   <= EMPTY;
              m_valid <= 1'b0;
            end
            (!pop && inflight): begin
              entry1 <= fifo_rd_data;
              state  <= TWO;
            end
            default: begin
            end
          endcase
        end
        TWO: begin
          if (pop) begin
            entry0 <= entry1;
            if (inflight) begin
              entry1 <= fifo_rd_data;
            end else begin
              state <= ONE;
            end
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_XFER_CNT_EN
  // Completed-transfer counter, wraps naturally at its width
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule
